// File: rtl/io_stream_array_buffer_pkg.sv
// Shared types and defaults for the stream/array frame buffer.
// Widths default to the legacy 8-bit data and address buses.
package io_stream_array_buffer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arr_op_t;

endpackage

// File: rtl/io_stream_array_buffer_out_reg.sv
// One-entry output register with valid/ready handshake.
// can_load tells the producer a load next edge cannot overrun.
module io_stream_array_buffer_out_reg
    import io_stream_array_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              take,
    output logic              can_load
);

    assign take     = out_valid & out_ready;
    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_data  <= '0;
            out_last  <= FALSE;
            out_valid <= FALSE;
        end else if (load) begin
            out_data  <= load_data;
            out_last  <= load_last;
            out_valid <= TRUE;
        end else if (take) begin
            out_valid <= FALSE;
        end
    end

endmodule

// File: rtl/io_stream_array_buffer.sv
// Frame buffer: fills an external array from a stream, then
// drains it forward or reversed onto an output stream.
module io_stream_array_buffer
    import io_stream_array_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              reverse,
    output logic [ADDR_W-1:0] arr_addr,
    output logic              arr_we,
    output logic [DATA_W-1:0] arr_di,
    input  logic [DATA_W-1:0] arr_do,
    output logic              arr_valid,
    input  logic              arr_ready
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]     count;
    logic [CW-1:0]     rd_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rev;
    logic              wr_last;
    logic              fill_open;

    logic in_fire;
    logic arr_fire;
    logic wr_done;
    logic rd_done;
    logic rd_issue;
    logic rd_last;
    logic out_take;
    logic can_load;
    logic drain_done;

    assign in_fire    = in_valid & in_ready;
    assign arr_fire   = arr_valid & arr_ready;
    assign wr_done    = arr_fire & arr_we;
    assign rd_done    = arr_fire & !arr_we;
    assign rd_last    = (rd_ptr == count - CW'(1));
    assign drain_done = (state == S_DRAIN) & out_take & out_last;

    // count holds the frame length n for the whole drain
    assign rd_addr = rev ? ADDR_W'(count - rd_ptr - CW'(1))
                         : rd_ptr[ADDR_W-1:0];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FILL: begin
                if (wr_done && wr_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_comb begin
        in_ready = FALSE;
        rd_issue = FALSE;
        unique case (state)
            S_FILL: begin
                in_ready = fill_open && !arr_valid;
            end
            S_DRAIN: begin
                rd_issue = !arr_valid && (rd_ptr < count)
                           && can_load;
            end
            default: begin
                in_ready = FALSE;
                rd_issue = FALSE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count     <= '0;
            rd_ptr    <= '0;
            rev       <= FALSE;
            wr_last   <= FALSE;
            fill_open <= FALSE;
            arr_valid <= FALSE;
            arr_we    <= OP_READ;
            arr_addr  <= '0;
            arr_di    <= '0;
        end else begin
            fill_open <= TRUE;
            if (in_fire) begin
                arr_valid <= TRUE;
                arr_we    <= OP_WRITE;
                arr_addr  <= count[ADDR_W-1:0];
                arr_di    <= in_data;
                wr_last   <= in_last || (count == LAST_IDX);
                if (count == '0) begin
                    rev <= reverse;
                end
            end else if (rd_issue) begin
                arr_valid <= TRUE;
                arr_we    <= OP_READ;
                arr_addr  <= rd_addr;
            end else if (arr_fire) begin
                arr_valid <= FALSE;
            end
            if (wr_done) begin
                count <= count + CW'(1);
            end
            if (rd_done) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            if (drain_done) begin
                count  <= '0;
                rd_ptr <= '0;
            end
        end
    end

    io_stream_array_buffer_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .nrst      (nrst),
        .load      (rd_done),
        .load_data (arr_do),
        .load_last (rd_last),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .take      (out_take),
        .can_load  (can_load)
    );

endmodule

// File: tb/tb_io_stream_array_buffer.sv
// Bench for io_stream_array_buffer: queue model of frames,
// plus directed frames with literal expected outputs.
module tb_io_stream_array_buffer;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic       sel;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       out_ready;
    logic       reverse;
    logic       arr_ready;

    logic       a_in_ready, a_out_last, a_out_valid;
    logic       a_arr_we, a_arr_valid;
    logic [7:0] a_out_data, a_arr_addr, a_arr_di, a_arr_do;
    logic       b_in_ready, b_out_last, b_out_valid;
    logic       b_arr_we, b_arr_valid;
    logic [7:0] b_out_data, b_arr_addr, b_arr_di, b_arr_do;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    assign a_arr_do = mem_a[a_arr_addr];
    assign b_arr_do = mem_b[b_arr_addr];

    always @(posedge clk) begin
        if (a_arr_valid && a_arr_we && arr_ready)
            mem_a[a_arr_addr] <= a_arr_di;
        if (b_arr_valid && b_arr_we && arr_ready)
            mem_b[b_arr_addr] <= b_arr_di;
    end

    io_stream_array_buffer #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(16)
    ) dut_a (
        .clk       (clk),
        .nrst      (nrst),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid & ~sel),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .out_valid (a_out_valid),
        .out_ready (out_ready & ~sel),
        .reverse   (reverse),
        .arr_addr  (a_arr_addr),
        .arr_we    (a_arr_we),
        .arr_di    (a_arr_di),
        .arr_do    (a_arr_do),
        .arr_valid (a_arr_valid),
        .arr_ready (arr_ready)
    );

    io_stream_array_buffer #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(256)
    ) dut_b (
        .clk       (clk),
        .nrst      (nrst),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid & sel),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .out_valid (b_out_valid),
        .out_ready (out_ready & sel),
        .reverse   (reverse),
        .arr_addr  (b_arr_addr),
        .arr_we    (b_arr_we),
        .arr_di    (b_arr_di),
        .arr_do    (b_arr_do),
        .arr_valid (b_arr_valid),
        .arr_ready (arr_ready)
    );

    logic       m_in_ready, m_out_last, m_out_valid;
    logic       m_arr_we, m_arr_valid;
    logic [7:0] m_out_data, m_arr_addr, m_arr_di;

    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_last  = sel ? b_out_last  : a_out_last;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_out_data  = sel ? b_out_data  : a_out_data;
    assign m_arr_we    = sel ? b_arr_we    : a_arr_we;
    assign m_arr_valid = sel ? b_arr_valid : a_arr_valid;
    assign m_arr_addr  = sel ? b_arr_addr  : a_arr_addr;
    assign m_arr_di    = sel ? b_arr_di    : a_arr_di;

    int checks = 0;
    int errors = 0;

    bit [7:0] frame[$];
    bit       rev_m;
    bit [7:0] exp_d[$];
    bit       exp_l[$];
    bit [7:0] exp_a[$];
    bit [7:0] wr_a[$];
    bit [7:0] wr_d[$];
    bit [7:0] got_d[$];
    bit       got_l[$];
    bit [7:0] got_a[$];
    bit       stall_h;
    bit [7:0] held_d;
    bit       held_l;
    int       gaps = 0;

    function automatic void chk(string nm, longint act,
                                longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endfunction

    function automatic void fail(string nm);
        checks++;
        errors++;
        $display("FAIL %s: event not expected by model", nm);
    endfunction

    // A closed frame becomes the expected output and read order.
    function automatic void close_frame();
        int n = frame.size();
        for (int i = 0; i < n; i++) begin
            int idx = rev_m ? n - 1 - i : i;
            exp_d.push_back(frame[idx]);
            exp_l.push_back(i == n - 1);
            exp_a.push_back(8'(idx));
        end
        frame.delete();
    endfunction

    always @(negedge clk) begin
        int depth_m;
        depth_m = sel ? 256 : 16;
        if (!nrst) begin
            chk("rst_outputs",
                {m_in_ready, m_out_valid, m_out_last,
                 m_arr_valid, m_arr_we, m_out_data,
                 m_arr_addr, m_arr_di}, 0);
            frame.delete();
            exp_d.delete();
            exp_l.delete();
            exp_a.delete();
            wr_a.delete();
            wr_d.delete();
            stall_h = 1'b0;
        end else begin
            if (stall_h) begin
                chk("hold_valid", m_out_valid, 1);
                chk("hold_data", m_out_data, held_d);
                chk("hold_last", m_out_last, held_l);
            end
            stall_h = m_out_valid && !out_ready;
            held_d  = m_out_data;
            held_l  = m_out_last;
            if (m_arr_valid && m_arr_we)
                chk("in_ready_wr_pend", m_in_ready, 0);
            if (exp_d.size() != 0)
                chk("in_ready_drain", m_in_ready, 0);
            if (m_out_valid && out_ready) begin
                got_d.push_back(m_out_data);
                got_l.push_back(m_out_last);
                if (exp_d.size() == 0) begin
                    fail("out_extra");
                end else begin
                    chk("out_data", m_out_data,
                        exp_d.pop_front());
                    chk("out_last", m_out_last,
                        exp_l.pop_front());
                end
            end
            if (m_arr_valid && arr_ready) begin
                if (m_arr_we) begin
                    if (wr_a.size() == 0) begin
                        fail("wr_extra");
                    end else begin
                        chk("wr_addr", m_arr_addr,
                            wr_a.pop_front());
                        chk("wr_data", m_arr_di,
                            wr_d.pop_front());
                    end
                end else begin
                    got_a.push_back(m_arr_addr);
                    if (exp_a.size() == 0) begin
                        fail("rd_extra");
                    end else begin
                        chk("rd_addr", m_arr_addr,
                            exp_a.pop_front());
                    end
                end
            end
            if (in_valid && m_in_ready) begin
                if (frame.size() == 0) rev_m = reverse;
                wr_a.push_back(8'(frame.size()));
                wr_d.push_back(in_data);
                frame.push_back(in_data);
                if (in_last || frame.size() == depth_m)
                    close_frame();
            end
        end
    end

    int or_mode = 0;
    int ar_mode = 0;
    int ph = 0;

    initial begin
        out_ready = 1'b0;
        arr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            arr_ready = (ar_mode == 0) ? 1'b1
                      : 1'($urandom_range(0, 1));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input bit [7:0] d, input bit l);
        int t = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!m_in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!m_in_ready) fail("in_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input bit [7:0] w[$],
                              input bit lastf,
                              input bit rv,
                              input bit rrev);
        reverse = rv;
        foreach (w[i]) begin
            if (gaps != 0) cyc($urandom_range(0, 2));
            send_word(w[i], lastf && (i == w.size() - 1));
            if (rrev) reverse = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        @(negedge clk);
        while (exp_d.size() != 0 && t < 8000) begin
            @(negedge clk);
            t++;
        end
        if (exp_d.size() != 0) fail("drain_timeout");
        cyc(3);
    endtask

    task automatic got_clear();
        got_d.delete();
        got_l.delete();
        got_a.delete();
    endtask

    task automatic check_got(string nm, input int e[$]);
        chk({nm, "_len"}, got_d.size(), e.size());
        for (int i = 0; i < e.size() && i < got_d.size(); i++) begin
            chk({nm, "_data"}, got_d[i], e[i]);
            chk({nm, "_last"}, got_l[i], i == e.size() - 1);
        end
    endtask

    task automatic check_addr(string nm, input int e[$]);
        chk({nm, "_len"}, got_a.size(), e.size());
        for (int i = 0; i < e.size() && i < got_a.size(); i++)
            chk(nm, got_a[i], e[i]);
    endtask

    initial begin
        int       e[$];
        bit [7:0] w[$];
        int       nbad;
        int       len;
        bit       lf;
        sel      = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_valid = 1'b0;
        reverse  = 1'b0;
        cyc(2);
        nrst = 1'b1;
        cyc(2);

        // reset mid-frame, then a clean 3-word frame
        w = '{0, 1, 2, 3, 4};
        send_frame(w, 0, 0, 0);
        nrst = 1'b0;
        cyc(1);
        nrst = 1'b1;
        cyc(2);
        got_clear();
        w = '{7, 8, 9};
        send_frame(w, 1, 0, 0);
        wait_drain();
        e = '{7, 8, 9};
        check_got("t1", e);

        // full 16-word forward frame without in_last
        got_clear();
        w.delete();
        e.delete();
        for (int i = 0; i < 16; i++) begin
            w.push_back(8'(i));
            e.push_back(i);
        end
        send_frame(w, 0, 0, 0);
        wait_drain();
        check_got("t2", e);

        // reverse short frame
        got_clear();
        w = '{3, 4, 5};
        send_frame(w, 1, 1, 0);
        wait_drain();
        e = '{5, 4, 3};
        check_got("t3", e);
        e = '{2, 1, 0};
        check_addr("t3_addr", e);

        // output back-pressure, ready 1 in 3 cycles
        or_mode = 1;
        got_clear();
        w = '{10, 11, 12, 13};
        send_frame(w, 1, 0, 0);
        wait_drain();
        e = '{10, 11, 12, 13};
        check_got("t4", e);

        // random array stalls and random frames
        or_mode = 2;
        ar_mode = 1;
        gaps    = 1;
        got_clear();
        w.delete();
        e.delete();
        for (int i = 0; i < 16; i++) begin
            w.push_back(8'($urandom));
            e.push_back(int'(w[i]));
        end
        send_frame(w, 0, 0, 1);
        wait_drain();
        check_got("t5", e);
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 16);
            lf  = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            w.delete();
            for (int i = 0; i < len; i++)
                w.push_back(8'($urandom));
            send_frame(w, lf, 1'($urandom_range(0, 1)), 1);
            wait_drain();
        end

        // single word, then a 256-word frame on the wide buffer
        or_mode = 0;
        ar_mode = 0;
        gaps    = 0;
        got_clear();
        w = '{42};
        send_frame(w, 1, 0, 0);
        wait_drain();
        e = '{42};
        check_got("t6_single", e);

        sel = 1'b1;
        cyc(2);
        got_clear();
        w.delete();
        e.delete();
        for (int i = 0; i < 256; i++) begin
            w.push_back(8'(i * 7 + 3));
            e.push_back((i * 7 + 3) % 256);
        end
        send_frame(w, 0, 0, 0);
        wait_drain();
        check_got("t6_big", e);
        nbad = 0;
        for (int i = 0; i < got_a.size(); i++)
            if (got_a[i] != 8'(i)) nbad++;
        chk("t6_addr_n", got_a.size(), 256);
        chk("t6_addr_cover", nbad, 0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
